// File: rtl/sha256_seq_pkg.sv
// Shared types and constants for the SHA-256 block sequencer.
package sha256_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPT,
    EMIT,
    WAIT_CORE,
    FIN
  } seq_state_e;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam int WORDS_PER_BLOCK = 16;

  // ceil((size+3)/16): room for the pad word plus the two length words
  function automatic logic [31:0] calc_num_blocks(input logic [31:0] size);
    return ((size + 32'd2) >> 4) + 32'd1;
  endfunction

endpackage

// File: rtl/sha256_pad_word_gen.sv
// Selects the schedule word for global word index g: memory data, pad word, zero fill or length.
// SHA_SEQ_BYTESWAP_EN byte-reverses memory words only.
module sha256_pad_word_gen
  import sha256_seq_pkg::*;
#(
  parameter int SIZE_W = 27
) (
  input  logic [SIZE_W:0]   g,
  input  logic [SIZE_W-1:0] size,
  input  logic [SIZE_W:0]   total,
  input  logic [31:0]       mem_data,
  output logic [31:0]       word,
  output logic              from_mem
);

  logic [31:0] mem_word;

`ifdef SHA_SEQ_BYTESWAP_EN
  assign mem_word = {mem_data[7:0], mem_data[15:8], mem_data[23:16], mem_data[31:24]};
`else
  assign mem_word = mem_data;
`endif

  // Length high word (total-2) falls through to the zero default
  always_comb begin
    from_mem = (g < {1'b0, size});
    word     = '0;
    if (from_mem) begin
      word = mem_word;
    end else if (g == {1'b0, size}) begin
      word = PAD_WORD;
    end else if (g == total - (SIZE_W + 1)'(1)) begin
      word = 32'({size, 5'b0});
    end
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Streams a padded message to the SHA-256 round core, 16 words per block.
// SHA_SEQ_BYTESWAP_EN (in sha256_pad_word_gen) byte-reverses memory words.
module sha256_block_sequencer
  import sha256_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SIZE_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [SIZE_W-1:0] size,
  output logic              busy,
  output logic              done,
  output logic [SIZE_W-4:0] num_blocks,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  input  logic [31:0]       mem_read_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data,
  output logic [3:0]        w_index,
  output logic              w_first,
  output logic              w_last,
  output logic              blk_last,
  input  logic              core_done
);

  localparam int G_W  = SIZE_W + 1;
  localparam int NB_W = SIZE_W - 3;

  seq_state_e        state;
  logic [ADDR_W-1:0] msg_addr_r;
  logic [SIZE_W-1:0] size_r;
  logic [G_W-1:0]    total_r;
  logic [G_W-1:0]    g;
  logic [G_W-1:0]    g_inc;
  logic [31:0]       gen_word;
  logic              gen_from_mem;

  assign g_inc = g + G_W'(1);

  sha256_pad_word_gen #(
    .SIZE_W (SIZE_W)
  ) u_word_gen (
    .g        (g),
    .size     (size_r),
    .total    (total_r),
    .mem_data (mem_read_data),
    .word     (gen_word),
    .from_mem (gen_from_mem)
  );

  // The read strobe is prepared on every transition into LOAD so it is high during LOAD itself
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_valid     <= 1'b0;
      mem_read_en <= 1'b0;
      w_first     <= 1'b0;
      w_last      <= 1'b0;
      blk_last    <= 1'b0;
      mem_addr    <= '0;
      w_data      <= '0;
      w_index     <= '0;
      num_blocks  <= '0;
      msg_addr_r  <= '0;
      size_r      <= '0;
      total_r     <= '0;
      g           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            msg_addr_r  <= message_addr;
            size_r      <= size;
            num_blocks  <= NB_W'(calc_num_blocks(32'(size)));
            total_r     <= {NB_W'(calc_num_blocks(32'(size))), 4'b0};
            g           <= '0;
            busy        <= 1'b1;
            mem_read_en <= (size != '0);
            mem_addr    <= message_addr;
            state       <= LOAD;
          end
        end
        LOAD, CAPT: begin
          mem_read_en <= 1'b0;
          if (state == LOAD && gen_from_mem) begin
            state <= CAPT;
          end else begin
            w_data   <= gen_word;
            w_valid  <= 1'b1;
            w_index  <= g[3:0];
            w_first  <= (g[3:0] == 4'd0);
            w_last   <= (g[3:0] == 4'(WORDS_PER_BLOCK - 1));
            blk_last <= (g[G_W-1:4] == num_blocks - NB_W'(1));
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (w_ready) begin
            w_valid <= 1'b0;
            g       <= g_inc;
            if (w_index == 4'(WORDS_PER_BLOCK - 1)) begin
              state <= WAIT_CORE;
            end else begin
              mem_read_en <= (g_inc < {1'b0, size_r});
              mem_addr    <= msg_addr_r + ADDR_W'(g_inc);
              state       <= LOAD;
            end
          end
        end
        WAIT_CORE: begin
          if (core_done) begin
            if (g == total_r) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              mem_read_en <= (g < {1'b0, size_r});
              mem_addr    <= msg_addr_r + ADDR_W'(g);
              state       <= LOAD;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Randomized bench for sha256_block_sequencer against a word-list reference model.
// Honours SHA_SEQ_BYTESWAP_EN for the expected memory words.
module tb_sha256_block_sequencer;

  localparam int ADDR_W = 16;
  localparam int SIZE_W = 27;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [SIZE_W-1:0] size;
  logic              busy;
  logic              done;
  logic [SIZE_W-4:0] num_blocks;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic [31:0]       mem_read_data;
  logic              w_valid;
  logic              w_ready;
  logic [31:0]       w_data;
  logic [3:0]        w_index;
  logic              w_first;
  logic              w_last;
  logic              blk_last;
  logic              core_done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mem_seed = 32'd0;

  always #5 clk = ~clk;

  sha256_block_sequencer #(
    .ADDR_W (ADDR_W),
    .SIZE_W (SIZE_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .message_addr  (message_addr),
    .size          (size),
    .busy          (busy),
    .done          (done),
    .num_blocks    (num_blocks),
    .mem_addr      (mem_addr),
    .mem_read_en   (mem_read_en),
    .mem_read_data (mem_read_data),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .w_index       (w_index),
    .w_first       (w_first),
    .w_last        (w_last),
    .blk_last      (blk_last),
    .core_done     (core_done)
  );

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'(a) ^ mem_seed;
  endfunction

  function automatic logic [31:0] expected_mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] d;
    d = mem_word(a);
`ifdef SHA_SEQ_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Memory answers one cycle after the strobe; garbage otherwise to expose mistimed captures
  always @(posedge clk) begin
    if (mem_read_en) mem_read_data <= mem_word(mem_addr);
    else             mem_read_data <= $urandom;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One message: build the expected word list, then play core and memory until done
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [SIZE_W-1:0] sz,
                               input int ready_pct, input bit noise, input int stall_at);
    logic [31:0] exp_q[$];
    logic [31:0] held_data;
    logic [3:0]  held_index;
    int nb, total, idx, reads, blocks, wait_cd, stall_left, cycles;
    bit awaiting_core, done_seen, hold_valid, stalled, noise_start, noise_core;
    nb = (int'(sz) + 3 + 15) / 16;
    total = nb * 16;
    for (int gi = 0; gi < total; gi++) begin
      if (gi < int'(sz))         exp_q.push_back(expected_mem_word(addr + ADDR_W'(gi)));
      else if (gi == int'(sz))   exp_q.push_back(32'h8000_0000);
      else if (gi == total - 1)  exp_q.push_back(32'(sz) * 32);
      else                       exp_q.push_back(32'h0);
    end
    idx = 0; reads = 0; blocks = 0; wait_cd = 0; stall_left = 0; cycles = 0;
    awaiting_core = 0; done_seen = 0; hold_valid = 0; stalled = 0;
    noise_start = 0; noise_core = 0; held_data = '0; held_index = '0;

    @(negedge clk);
    message_addr = addr;
    size = sz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    message_addr = ADDR_W'($urandom);
    size = SIZE_W'($urandom);
    checkOutput("busy_after_start", busy, 1);
    checkOutput("num_blocks", num_blocks, nb);

    while (!done_seen && cycles < 3000) begin
      if (hold_valid) begin
        checkOutput("hold_valid", w_valid, 1);
        checkOutput("hold_data", w_data, held_data);
        checkOutput("hold_index", w_index, held_index);
      end
      if (mem_read_en) begin
        checkOutput("rd_addr", mem_addr, ADDR_W'(addr + ADDR_W'(reads)));
        checkOutput("rd_order", reads, idx);
        checkOutput("rd_in_msg", (reads < int'(sz)) ? 1 : 0, 1);
        reads++;
      end
      if (awaiting_core) checkOutput("valid_in_wait", w_valid, 0);
      if (done) begin
        done_seen = 1;
        checkOutput("done_words", idx, total);
        checkOutput("done_blocks", blocks, nb);
        checkOutput("done_reads", reads, sz);
        checkOutput("done_busy", busy, 1);
      end

      start = 1'b0;
      core_done = 1'b0;
      if (awaiting_core) begin
        if (wait_cd == 0) begin
          core_done = 1'b1;
          awaiting_core = 0;
          blocks++;
        end else begin
          wait_cd--;
          if (noise && !noise_start) begin
            start = 1'b1;
            size = SIZE_W'($urandom_range(0, 60));
            noise_start = 1;
          end
        end
      end else if (noise && w_valid && !noise_core) begin
        core_done = 1'b1;
        noise_core = 1;
      end

      if (stall_left > 0) begin
        w_ready = 1'b0;
        stall_left--;
      end else if (w_valid && idx == stall_at && !stalled) begin
        w_ready = 1'b0;
        stall_left = 4;
        stalled = 1;
      end else begin
        w_ready = ($urandom_range(0, 99) < ready_pct);
      end

      if (w_valid && w_ready) begin
        if (idx < total) begin
          checkOutput("w_data", w_data, exp_q[idx]);
          checkOutput("w_index", w_index, idx % 16);
          checkOutput("w_first", w_first, (idx % 16 == 0) ? 1 : 0);
          checkOutput("w_last", w_last, (idx % 16 == 15) ? 1 : 0);
          checkOutput("blk_last", blk_last, (idx / 16 == nb - 1) ? 1 : 0);
          if (idx % 16 == 15) begin
            awaiting_core = 1;
            wait_cd = $urandom_range(0, 3);
          end
        end else begin
          checkOutput("extra_word", idx, total - 1);
        end
        idx++;
        hold_valid = 0;
      end else if (w_valid) begin
        hold_valid = 1;
        held_data = w_data;
        held_index = w_index;
      end else begin
        hold_valid = 0;
      end

      @(negedge clk);
      cycles++;
    end

    core_done = 1'b0;
    start = 1'b0;
    if (!done_seen) begin
      checkOutput("timeout", 0, 1);
    end else begin
      checkOutput("done_pulse", done, 0);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("num_blocks_kept", num_blocks, nb);
    end
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, "_busy"}, busy, 0);
    checkOutput({phase, "_done"}, done, 0);
    checkOutput({phase, "_w_valid"}, w_valid, 0);
    checkOutput({phase, "_mem_read_en"}, mem_read_en, 0);
    checkOutput({phase, "_w_first"}, w_first, 0);
    checkOutput({phase, "_w_last"}, w_last, 0);
    checkOutput({phase, "_blk_last"}, blk_last, 0);
    checkOutput({phase, "_mem_addr"}, mem_addr, 0);
    checkOutput({phase, "_w_data"}, w_data, 0);
    checkOutput({phase, "_w_index"}, w_index, 0);
    checkOutput({phase, "_num_blocks"}, num_blocks, 0);
  endtask

  // Abort a 20-word message partway through block 0
  task automatic resetAbort();
    int accepted, cycles;
    accepted = 0;
    cycles = 0;
    mem_seed = $urandom;
    @(negedge clk);
    message_addr = ADDR_W'($urandom);
    size = SIZE_W'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w_ready = 1'b1;
    while (accepted < 5 && cycles < 500) begin
      if (w_valid) accepted++;
      @(negedge clk);
      cycles++;
    end
    checkOutput("abort_progress", (accepted >= 5) ? 1 : 0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkAllZero("abort");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    message_addr = '0;
    size = '0;
    w_ready = 1'b0;
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkAllZero("reset");

    mem_seed = 32'd0;
    applyStimulus(16'h0000, 27'd0, 100, 0, -1);
    applyStimulus(16'h0000, 27'd13, 100, 0, -1);
    mem_seed = $urandom;
    applyStimulus(16'h0100, 27'd14, 100, 0, -1);
    applyStimulus(16'h0200, 27'd3, 100, 0, 1);
    applyStimulus(16'h0300, 27'd15, 80, 1, -1);
    applyStimulus(16'hFFFE, 27'd5, 70, 1, 2);
    applyStimulus(16'h0400, 27'd29, 60, 1, -1);

    for (int t = 0; t < 6; t++) begin
      mem_seed = $urandom;
      applyStimulus(ADDR_W'($urandom), SIZE_W'($urandom_range(0, 40)),
                    $urandom_range(30, 100), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 20));
    end

    resetAbort();
    mem_seed = $urandom;
    applyStimulus(16'h0500, 27'd1, 100, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
